pll_reset_sequencer: RTL and testbench

Generates the core reset from PLL lock status. Runs in the PLL output clock domain at 16 MHz from a 12 MHz reference. It synchronises the asynchronous PLL lock flag and requires lock to stay stable for a set time. It then holds the core in reset for a few more cycles before releasing it, and re-asserts reset whenever lock drops. It sits between the PLL wrapper and every reset input of the processor core.

---
 rtl/pll_rst_pkg.sv | 26 ++
 rtl/sync_ff_chain.sv | 27 ++
 rtl/pll_reset_sequencer.sv | 104 ++++++++++
 tb/tb_pll_reset_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_rst_pkg.sv
// Shared types and defaults for the PLL-lock driven core reset sequencer.
package pll_rst_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } rst_state_t;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_HOLD_CYCLES    = 16;
  localparam int DEF_TIMEOUT_CYCLES = 65536;
  localparam int RELOCK_W           = 8;

  // Width that holds (largest cycle count - 1) without wrapping; never below 1.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchroniser for a single asynchronous level input.
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_ff_chain: STAGES must be >= 2");
  end

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds the core in reset until PLL lock has been stable, then releases it;
// lock loss or a soft request in RUN puts the core back into reset.
module pll_reset_sequencer
  import pll_rst_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pll_lock,
  input  logic                soft_rst_req,
  output logic                core_rst_n,
  output logic                ready,
  output logic                lock_timeout,
  output logic [RELOCK_W-1:0] relock_count
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES, HOLD_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("pll_reset_sequencer: SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("pll_reset_sequencer: STABLE_CYCLES must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("pll_reset_sequencer: HOLD_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("pll_reset_sequencer: TIMEOUT_CYCLES must be >= 1");
  end

  logic             lock_s;
  rst_state_t       state;
  rst_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;

  sync_ff_chain #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (pll_lock),
    .q    (lock_s)
  );

  // Lock loss always wins over a soft request; soft requests only act in RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_LOCK: if (lock_s) state_nxt = STABILIZE;
      STABILIZE: begin
        if (!lock_s)                 state_nxt = WAIT_LOCK;
        else if (cnt == STABLE_LAST) state_nxt = HOLD;
      end
      HOLD: begin
        if (!lock_s)               state_nxt = WAIT_LOCK;
        else if (cnt == HOLD_LAST) state_nxt = RUN;
      end
      RUN: begin
        if (!lock_s)          state_nxt = WAIT_LOCK;
        else if (soft_rst_req) state_nxt = HOLD;
      end
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= WAIT_LOCK;
      cnt          <= '0;
      core_rst_n   <= 1'b0;
      ready        <= 1'b0;
      lock_timeout <= 1'b0;
      relock_count <= '0;
    end else begin
      state      <= state_nxt;
      core_rst_n <= (state_nxt == RUN);
      ready      <= (state_nxt == RUN);

      // Staying in STABILIZE/HOLD implies cnt is below its terminal value.
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (state != RUN && !(state == WAIT_LOCK && cnt == TIMEOUT_LAST)) begin
        cnt <= cnt + 1'b1;
      end

      if (state == WAIT_LOCK && !lock_s && cnt == TIMEOUT_LAST) begin
        lock_timeout <= 1'b1;
      end

      if (state == RUN && !lock_s && relock_count != '1) begin
        relock_count <= relock_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: timestamp-based reference model with a
// per-cycle compare, plus directed literal checks on a small and a default instance.
module tb_pll_reset_sequencer;

  localparam int SYNC  = 2;
  localparam int STAB  = 8;
  localparam int HOLDC = 4;
  localparam int TOUT  = 32;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, pll_lock, soft_rst_req;
  logic       core_rst_n, ready, lock_timeout;
  logic [7:0] relock_count;

  logic       rst_n_d, pll_lock_d, soft_d;
  logic       core_rst_n_d, ready_d, lock_timeout_d;
  logic [7:0] relock_count_d;

  pll_reset_sequencer #(
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STAB),
    .HOLD_CYCLES   (HOLDC),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_lock    (pll_lock),
    .soft_rst_req(soft_rst_req),
    .core_rst_n  (core_rst_n),
    .ready       (ready),
    .lock_timeout(lock_timeout),
    .relock_count(relock_count)
  );

  pll_reset_sequencer dut_def (
    .clk         (clk),
    .rst_n       (rst_n_d),
    .pll_lock    (pll_lock_d),
    .soft_rst_req(soft_d),
    .core_rst_n  (core_rst_n_d),
    .ready       (ready_d),
    .lock_timeout(lock_timeout_d),
    .relock_count(relock_count_d)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Driver helper: advance to just after the next k rising edges.
  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: lock_s is pll_lock delayed by SYNC edges; release is a
  // scheduled edge number; timeout is measured from the start of a lock-low run.
  logic [10:0] exp_q[$];
  bit          hist_q[$];
  int          n_m        = 0;
  bit          ready_m    = 1'b0;
  bit          to_m       = 1'b0;
  int          relock_m   = 0;
  int          release_at = -1;
  int          wait_since = 0;
  bit          prev_ls    = 1'b0;
  bit          ls;

  task automatic model_reset();
    n_m        = 0;
    ready_m    = 1'b0;
    to_m       = 1'b0;
    relock_m   = 0;
    release_at = -1;
    wait_since = 0;
    prev_ls    = 1'b0;
    hist_q.delete();
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      ls = (hist_q.size() >= SYNC) ? hist_q.pop_front() : 1'b0;
      hist_q.push_back(pll_lock);
      if (!ls) begin
        if (ready_m && relock_m < 255) relock_m++;
        ready_m    = 1'b0;
        release_at = -1;
        if (prev_ls) wait_since = n_m + 1;
        else if (n_m - wait_since >= TOUT - 1) to_m = 1'b1;
      end else if (ready_m) begin
        if (soft_rst_req) begin
          ready_m    = 1'b0;
          release_at = n_m + HOLDC;
        end
      end else begin
        if (!prev_ls) release_at = n_m + STAB + HOLDC;
        else if (n_m == release_at) ready_m = 1'b1;
      end
      prev_ls = ls;
      n_m++;
    end
    exp_q.push_back({ready_m, ready_m, to_m, 8'(relock_m)});
  end

  // Scoreboard compare, every cycle, away from the active edge.
  logic [10:0] exp_e;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_e = exp_q.pop_front();
      check("model_core_rst_n",   32'(core_rst_n),   32'(exp_e[10]));
      check("model_ready",        32'(ready),        32'(exp_e[9]));
      check("model_lock_timeout", 32'(lock_timeout), 32'(exp_e[8]));
      check("model_relock_count", 32'(relock_count), 32'(exp_e[7:0]));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, mismatched=%0d", mismatched);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; pll_lock = 1'b0; soft_rst_req = 1'b0;
    rst_n_d = 1'b0; pll_lock_d = 1'b0; soft_d = 1'b0;
    tick(3);
    check("rst_core",    32'(core_rst_n),   0);
    check("rst_ready",   32'(ready),        0);
    check("rst_timeout", 32'(lock_timeout), 0);
    check("rst_relock",  32'(relock_count), 0);
    check("rst_def_core", 32'(core_rst_n_d), 0);

    // Clean startup: release after edge 14
    rst_n = 1'b1; pll_lock = 1'b1;
    tick(14);
    check("s1_core_e13",  32'(core_rst_n), 0);
    check("s1_ready_e13", 32'(ready),      0);
    tick(1);
    check("s1_core_e14",  32'(core_rst_n),   1);
    check("s1_ready_e14", 32'(ready),        1);
    check("s1_timeout",   32'(lock_timeout), 0);

    // Soft reset in RUN: low for HOLD_CYCLES edges
    soft_rst_req = 1'b1; tick(1); soft_rst_req = 1'b0;
    check("s4_soft_low_e0", 32'(core_rst_n), 0);
    tick(3);
    check("s4_soft_low_e3", 32'(core_rst_n), 0);
    tick(1);
    check("s4_soft_high_e4", 32'(core_rst_n), 1);

    // Single lock loss in RUN
    pll_lock = 1'b0;
    tick(2);
    check("s3_loss_e1_core", 32'(core_rst_n), 1);
    tick(1);
    check("s3_loss_e2_core", 32'(core_rst_n),   0);
    check("s3_loss_relock",  32'(relock_count), 1);
    pll_lock = 1'b1;
    tick(14);
    check("s3_relock_e13", 32'(core_rst_n), 0);
    tick(1);
    check("s3_relock_e14", 32'(core_rst_n), 1);

    // Soft request during STABILIZE is ignored
    pll_lock = 1'b0; tick(3);
    pll_lock = 1'b1; tick(5);
    soft_rst_req = 1'b1; tick(1); soft_rst_req = 1'b0;
    tick(8);
    check("s4_stab_soft_e13", 32'(core_rst_n), 0);
    tick(1);
    check("s4_stab_soft_e14", 32'(core_rst_n),   1);
    check("s4_stab_relock",   32'(relock_count), 2);

    // Lock loss and soft request on the same edge: loss wins
    pll_lock = 1'b0; tick(2);
    soft_rst_req = 1'b1; tick(1); soft_rst_req = 1'b0;
    check("s4_prio_core",   32'(core_rst_n),   0);
    check("s4_prio_relock", 32'(relock_count), 3);
    pll_lock = 1'b1; tick(15);
    check("s4_prio_rerun", 32'(core_rst_n), 1);

    // Async reset in RUN clears everything without a clock edge
    #2 rst_n = 1'b0;
    #1;
    check("s6_async_core",   32'(core_rst_n),   0);
    check("s6_async_ready",  32'(ready),        0);
    check("s6_async_relock", 32'(relock_count), 0);
    tick(2);
    rst_n = 1'b1;

    // Glitch during STABILIZE restarts the full count
    tick(5);
    pll_lock = 1'b0; tick(3);
    pll_lock = 1'b1; tick(14);
    check("s2_glitch_e21", 32'(core_rst_n), 0);
    tick(1);
    check("s2_glitch_e22", 32'(core_rst_n),   1);
    check("s2_relock",     32'(relock_count), 0);

    // Repeated losses saturate relock_count
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b0; tick(4);
      pll_lock = 1'b1; tick(15);
    end
    check("s3_sat_relock", 32'(relock_count), 255);
    check("s3_sat_core",   32'(core_rst_n),   1);

    // Timeout with lock held low from reset
    #2 rst_n = 1'b0; pll_lock = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(31);
    check("s5_timeout_e30", 32'(lock_timeout), 0);
    tick(1);
    check("s5_timeout_e31", 32'(lock_timeout), 1);
    pll_lock = 1'b1; tick(15);
    check("s5_after_lock_core",    32'(core_rst_n),   1);
    check("s5_after_lock_timeout", 32'(lock_timeout), 1);
    #2 rst_n = 1'b0;
    #1;
    check("s5_rst_clears_timeout", 32'(lock_timeout), 0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    check("s5_timeout_stays_clear", 32'(lock_timeout), 0);

    // Default-parameter instance: startup, loss, async reset mid-HOLD
    rst_n_d = 1'b1; pll_lock_d = 1'b1;
    tick(1042);
    check("s6d_start_e1041", 32'(core_rst_n_d), 0);
    tick(1);
    check("s6d_start_e1042_core",  32'(core_rst_n_d), 1);
    check("s6d_start_e1042_ready", 32'(ready_d),      1);
    pll_lock_d = 1'b0; tick(3);
    check("s6d_loss_core",   32'(core_rst_n_d),   0);
    check("s6d_loss_relock", 32'(relock_count_d), 1);
    pll_lock_d = 1'b1; tick(1035);
    check("s6d_in_hold_core", 32'(core_rst_n_d), 0);
    #2 rst_n_d = 1'b0;
    #1;
    check("s6d_async_core",    32'(core_rst_n_d),   0);
    check("s6d_async_ready",   32'(ready_d),        0);
    check("s6d_async_relock",  32'(relock_count_d), 0);
    check("s6d_async_timeout", 32'(lock_timeout_d), 0);
    tick(1);
    rst_n_d = 1'b1;
    tick(1042);
    check("s6d_restart_e1041", 32'(core_rst_n_d), 0);
    tick(1);
    check("s6d_restart_e1042", 32'(core_rst_n_d), 1);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
